// File: rtl/traffic_monitor.sv
// Passive lamp-bus checker for the intersection controller.
// Decodes per-direction aspects, flags sticky faults, reports phase timing.
module traffic_monitor #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_HOLD  = 100,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [6:0]    lights,
  input  logic          err_clr,
  output logic          err_conflict,
  output logic          err_seq,
  output logic          err_lamp,
  output logic          err_short,
  output logic          err_stuck,
  output logic [CW-1:0] phase_count,
  output logic [CW-1:0] last_dur,
  output logic [15:0]   cycle_cnt,
  output logic          cycle_pulse
);

  typedef enum logic [2:0] {
    A_DARK, A_RED, A_RAMB, A_AMB, A_GRN
  } asp_e;

  typedef enum logic {S_INIT, S_RUN} st_e;

  localparam logic [CW-1:0] L_SAT   = '1;
  localparam logic [CW-1:0] L_ONE   = CW'(1);
  localparam logic [CW-1:0] L_MAXH  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] L_MING  = CW'(MIN_GREEN);

  function automatic asp_e f_dec(input logic [2:0] v);
    case (v)
      3'b100:  return A_RED;
      3'b110:  return A_RAMB;
      3'b010:  return A_AMB;
      3'b001:  return A_GRN;
      default: return A_DARK;
    endcase
  endfunction

  function automatic logic f_bad(input logic [2:0] v);
    return !(v inside {3'b000, 3'b100, 3'b110, 3'b010, 3'b001});
  endfunction

  function automatic logic f_act(input asp_e a);
    return (a == A_RAMB) || (a == A_AMB) || (a == A_GRN);
  endfunction

  function automatic logic f_legal(input asp_e p, input asp_e c);
    if (p == c || c == A_DARK || p == A_DARK) return 1'b1;
    return (p == A_RED  && c == A_RAMB) ||
           (p == A_RED  && c == A_GRN)  ||
           (p == A_RAMB && c == A_GRN)  ||
           (p == A_GRN  && c == A_AMB)  ||
           (p == A_AMB  && c == A_RED);
  endfunction

  st_e          r_state;
  logic [5:0]   r_pat;
  asp_e         r_ns_a;
  asp_e         r_ew_a;
  logic [CW-1:0] r_ns_g;
  logic [CW-1:0] r_ew_g;

  asp_e          w_ns_a;
  asp_e          w_ew_a;
  logic          w_run;
  logic          w_same;
  logic          w_lamp;
  logic          w_conf;
  logic          w_seq;
  logic          w_short;
  logic          w_stuck;
  logic          w_enter;
  logic [CW-1:0] w_pc_inc;
  logic [CW-1:0] w_ns_g_nx;
  logic [CW-1:0] w_ew_g_nx;
  logic          w_unused;

  assign w_unused = lights[6];

  assign w_ns_a = f_dec(lights[5:3]);
  assign w_ew_a = f_dec(lights[2:0]);
  assign w_run  = (r_state == S_RUN);
  assign w_same = (lights[5:0] == r_pat);

  assign w_lamp = f_bad(lights[5:3]) | f_bad(lights[2:0]);
  assign w_conf = f_act(w_ns_a) & f_act(w_ew_a);

  assign w_seq = w_run &&
    (!f_legal(r_ns_a, w_ns_a) || !f_legal(r_ew_a, w_ew_a));

  // Leaving GREEN to any aspect, DARK included, is timed here.
  assign w_short = w_run && (
    (r_ns_a == A_GRN && w_ns_a != A_GRN && r_ns_g < L_MING) ||
    (r_ew_a == A_GRN && w_ew_a != A_GRN && r_ew_g < L_MING));

  assign w_pc_inc = (phase_count == L_SAT) ? phase_count
                                           : phase_count + L_ONE;

  assign w_stuck = w_run && w_same && (w_pc_inc >= L_MAXH) &&
                   (w_ns_a != A_DARK || w_ew_a != A_DARK);

  assign w_enter = w_run && r_ns_a != A_GRN && w_ns_a == A_GRN;

  assign w_ns_g_nx = (w_ns_a != A_GRN) ? '0 :
                     (r_ns_g == L_SAT) ? r_ns_g : r_ns_g + L_ONE;
  assign w_ew_g_nx = (w_ew_a != A_GRN) ? '0 :
                     (r_ew_g == L_SAT) ? r_ew_g : r_ew_g + L_ONE;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state      <= S_INIT;
      r_pat        <= '0;
      r_ns_a       <= A_DARK;
      r_ew_a       <= A_DARK;
      r_ns_g       <= '0;
      r_ew_g       <= '0;
      phase_count  <= '0;
      last_dur     <= '0;
      cycle_cnt    <= '0;
      cycle_pulse  <= 1'b0;
      err_conflict <= 1'b0;
      err_seq      <= 1'b0;
      err_lamp     <= 1'b0;
      err_short    <= 1'b0;
      err_stuck    <= 1'b0;
    end else begin
      r_state <= S_RUN;
      r_pat   <= lights[5:0];
      r_ns_a  <= w_ns_a;
      r_ew_a  <= w_ew_a;
      r_ns_g  <= w_ns_g_nx;
      r_ew_g  <= w_ew_g_nx;

      if (!w_run) begin
        phase_count <= '0;
      end else if (w_same) begin
        phase_count <= w_pc_inc;
      end else begin
        phase_count <= '0;
        last_dur    <= w_pc_inc;
      end

      cycle_pulse <= w_enter;
      if (w_enter) cycle_cnt <= cycle_cnt + 16'd1;

      // A fault in the same cycle as err_clr wins.
      err_conflict <= (err_conflict & ~err_clr) | w_conf;
      err_seq      <= (err_seq      & ~err_clr) | w_seq;
      err_lamp     <= (err_lamp     & ~err_clr) | w_lamp;
      err_short    <= (err_short    & ~err_clr) | w_short;
      err_stuck    <= (err_stuck    & ~err_clr) | w_stuck;
    end
  end

endmodule

// File: tb/tb_traffic_monitor.sv
// Scoreboard bench for traffic_monitor: directed scenarios plus random
// lamp traffic checked against a run-length reference model.
module tb_traffic_monitor;

  localparam int MIN_G  = 4;
  localparam int MAX_H  = 100;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        err_clr = 1'b0;
  logic [6:0]  lights = '0;
  logic        err_conflict, err_seq, err_lamp, err_short, err_stuck;
  logic [7:0]  phase_count, last_dur;
  logic [15:0] cycle_cnt;
  logic        cycle_pulse;

  traffic_monitor #(.MIN_GREEN(MIN_G), .MAX_HOLD(MAX_H), .CW(8)) dut (
    .clk(clk), .clr(clr), .lights(lights), .err_clr(err_clr),
    .err_conflict(err_conflict), .err_seq(err_seq),
    .err_lamp(err_lamp), .err_short(err_short),
    .err_stuck(err_stuck), .phase_count(phase_count),
    .last_dur(last_dur), .cycle_cnt(cycle_cnt),
    .cycle_pulse(cycle_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       conf, seq, lamp, shrt, stuck;
    logic [7:0] pc, ld;
    logic [15:0] cnt;
    logic       pulse;
  } obs_t;

  obs_t q[$];
  obs_t mon_exp, mon_got;
  int n_chk = 0;
  int n_pass = 0;

  // Aspect codes: 0 dark, 1 red, 2 red+amber, 3 amber, 4 green, 5 bad
  localparam logic [6:0] P_DARK = 7'b0_000_000;
  localparam logic [6:0] P_RR   = 7'b0_100_100;
  localparam logic [6:0] P_NSG  = 7'b0_001_100;
  localparam logic [6:0] P_NSA  = 7'b0_010_100;
  localparam logic [6:0] P_EWG  = 7'b0_100_001;
  localparam logic [6:0] P_EWA  = 7'b0_100_010;
  localparam logic [6:0] P_BOTHG = 7'b0001001;
  localparam logic [6:0] P_LAMP = 7'b0_101_100;

  bit legal[6][6];
  bit m_init, m_conf, m_seq, m_lamp, m_short, m_stuck, m_pulse;
  int m_run, m_last, m_cnt, m_pns, m_pew, m_gns, m_gew;
  logic [5:0] m_pat;

  function automatic int dec(input logic [2:0] v);
    case (v)
      3'b000: return 0;
      3'b100: return 1;
      3'b110: return 2;
      3'b010: return 3;
      3'b001: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic mreset();
    m_init = 1; m_conf = 0; m_seq = 0; m_lamp = 0;
    m_short = 0; m_stuck = 0; m_pulse = 0;
    m_run = 0; m_last = 0; m_cnt = 0;
    m_pns = 0; m_pew = 0; m_gns = 0; m_gew = 0; m_pat = '0;
  endtask

  task automatic mstep(input logic c, input logic e, input logic [6:0] l);
    int ns, es, na, ea;
    bit s_conf, s_seq, s_lamp, s_short, s_stuck;
    obs_t o;
    if (c) begin
      mreset();
    end else begin
      ns = dec(l[5:3]);
      es = dec(l[2:0]);
      s_lamp = (ns == 5) || (es == 5);
      na = (ns == 5) ? 0 : ns;
      ea = (es == 5) ? 0 : es;
      s_conf = (na >= 2) && (ea >= 2);
      s_seq = 0; s_short = 0; s_stuck = 0; m_pulse = 0;
      if (m_init) begin
        m_run = 1;
      end else begin
        if (l[5:0] == m_pat) m_run++;
        else begin m_last = sat(m_run); m_run = 1; end
        s_seq = !legal[m_pns][na] || !legal[m_pew][ea];
        s_short = (m_pns == 4 && na != 4 && m_gns < MIN_G) ||
                  (m_pew == 4 && ea != 4 && m_gew < MIN_G);
        if (m_pns != 4 && na == 4) begin
          m_cnt = (m_cnt + 1) % 65536;
          m_pulse = 1;
        end
        s_stuck = (m_run - 1 >= MAX_H) && (na != 0 || ea != 0);
      end
      m_gns = (na == 4) ? m_gns + 1 : 0;
      m_gew = (ea == 4) ? m_gew + 1 : 0;
      m_conf  = (m_conf  && !e) || s_conf;
      m_seq   = (m_seq   && !e) || s_seq;
      m_lamp  = (m_lamp  && !e) || s_lamp;
      m_short = (m_short && !e) || s_short;
      m_stuck = (m_stuck && !e) || s_stuck;
      m_pat = l[5:0]; m_pns = na; m_pew = ea; m_init = 0;
    end
    o.conf = m_conf; o.seq = m_seq; o.lamp = m_lamp;
    o.shrt = m_short; o.stuck = m_stuck;
    o.pc = 8'((m_run == 0) ? 0 : sat(m_run - 1));
    o.ld = 8'(m_last);
    o.cnt = 16'(m_cnt);
    o.pulse = m_pulse;
    q.push_back(o);
  endtask

  task automatic drive(input logic c, input logic e, input logic [6:0] l);
    @(negedge clk);
    clr = c; err_clr = e; lights = l;
    mstep(c, e, l);
  endtask

  task automatic hold(input logic [6:0] l, input int n);
    repeat (n) drive(1'b0, 1'b0, l);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_exp = q.pop_front();
        mon_got = {err_conflict, err_seq, err_lamp, err_short, err_stuck,
                   phase_count, last_dur, cycle_cnt, cycle_pulse};
        n_chk++;
        if (mon_got === mon_exp) n_pass++;
        else $display("FAIL outputs t=%0t got=%h exp=%h",
                      $time, mon_got, mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  logic [2:0] asp_bits[5];
  logic [6:0] rl;
  int nh;

  initial begin
    for (int p = 0; p < 6; p++)
      for (int c = 0; c < 6; c++)
        legal[p][c] = (p == c) || (c == 0) || (p == 0);
    legal[1][2] = 1; legal[1][4] = 1; legal[2][4] = 1;
    legal[4][3] = 1; legal[3][1] = 1;
    asp_bits = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b001};
    mreset();

    drive(1, 0, P_DARK);
    drive(1, 0, P_DARK);
    drive(0, 0, P_DARK);

    for (int r = 0; r < 2; r++) begin
      hold(P_NSG, 16);
      if (r == 0) begin
        hold(P_NSA, 1);
        settle();
        chk("last_dur_16", last_dur, 16);
        hold(P_NSA, 3);
      end else hold(P_NSA, 4);
      hold(P_RR, 4);
      hold(P_EWG, 16);
      hold(P_EWA, 4);
      hold(P_RR, 4);
    end
    settle();
    chk("cycle_cnt_2", cycle_cnt, 2);
    chk("nominal_flags",
        {err_conflict, err_seq, err_lamp, err_short, err_stuck}, 0);

    drive(0, 0, P_BOTHG);
    settle();
    chk("conflict_set", err_conflict, 1);
    hold(P_DARK, 3);
    settle();
    chk("conflict_held", err_conflict, 1);
    drive(0, 1, P_DARK);
    settle();
    chk("conflict_cleared",
        {err_conflict, err_seq, err_lamp, err_short, err_stuck}, 0);

    hold(P_RR, 2);
    hold(P_NSG, 5);
    drive(0, 0, P_RR);
    settle();
    chk("seq_green_red", err_seq, 1);
    chk("no_short_long_green", err_short, 0);
    drive(0, 1, P_RR);

    hold(P_NSG, 2);
    drive(0, 0, P_NSA);
    settle();
    chk("short_green", err_short, 1);
    drive(0, 0, P_LAMP);
    settle();
    chk("lamp_101", err_lamp, 1);
    drive(0, 1, P_DARK);

    hold(P_RR, 50);
    settle();
    chk("stuck_early", err_stuck, 0);
    hold(P_RR, 250);
    settle();
    chk("stuck_set", err_stuck, 1);
    chk("phase_sat", phase_count, 255);
    drive(0, 1, P_DARK);
    hold(P_DARK, 299);
    settle();
    chk("dark_not_stuck", err_stuck, 0);
    chk("dark_phase_sat", phase_count, 255);

    hold(P_RR, 3);
    drive(0, 0, P_NSG);
    drive(1, 0, P_NSG);
    settle();
    chk("reset_outputs",
        {err_conflict, err_seq, err_lamp, err_short, err_stuck,
         phase_count, last_dur, cycle_cnt, cycle_pulse}, 0);
    hold(P_NSA, 4);
    hold(P_RR, 2);
    settle();
    chk("reset_no_short", err_short, 0);
    chk("reset_no_seq", err_seq, 0);

    drive(0, 1, P_BOTHG);
    settle();
    chk("set_beats_clear", err_conflict, 1);
    drive(0, 1, P_DARK);

    begin
      int k;
      k = 0;
      while (k < 2500) begin
        rl[6] = 1'($urandom);
        rl[5:3] = ($urandom_range(0, 9) == 0) ? 3'($urandom)
                  : asp_bits[$urandom_range(0, 4)];
        rl[2:0] = ($urandom_range(0, 9) == 0) ? 3'($urandom)
                  : asp_bits[$urandom_range(0, 4)];
        nh = ($urandom_range(0, 19) == 0) ? $urandom_range(90, 130)
             : $urandom_range(1, 8);
        repeat (nh) begin
          drive(1'($urandom_range(0, 299) == 0),
                1'($urandom_range(0, 24) == 0), rl);
          k++;
        end
      end
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
